// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_e        : sequencer states of the serial datapath
//   DEFAULT_WIDTH  : default operand width
//   ref_sub()      : word-level reference, returns {borrowout, diff}
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Result in bits [31:0] masked to 'width', borrow in bit 32.
  function automatic logic [32:0] ref_sub(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        bin,
                                          input int unsigned width);
    logic [31:0] mask;
    logic [32:0] full;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    full = {1'b0, a & mask} - {1'b0, b & mask} - {32'd0, bin};
    return {full[32], full[31:0] & mask};
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// Combinational single-bit full subtractor.
//   a, b      : minuend / subtrahend bit
//   borrowin  : incoming borrow
//   diff      : a ^ b ^ borrowin
//   borrowout : borrow generated toward the next bit
module full_subtractor_bit (
  output logic diff,
  output logic borrowout,
  input  logic a,
  input  logic b,
  input  logic borrowin
);

  assign diff      = a ^ b ^ borrowin;
  assign borrowout = (~a & b) | (~(a ^ b) & borrowin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, borrowin sampled here)
//   out_valid / out_ready: result handshake
//   diff                 : (a - b - borrowin) mod 2^WIDTH
//   borrowout            : 1 iff a < b + borrowin
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrowout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bor_q, bor_d;
  logic             bit_diff;
  logic             bit_bor;

  full_subtractor_bit u_bit (
    .diff      (bit_diff),
    .borrowout (bit_bor),
    .a         (a_q[0]),
    .b         (b_q[0]),
    .borrowin  (bor_q)
  );

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign borrowout = bor_q;

  // bor_q doubles as the running borrow during RUN and the final borrow in DONE.
  // RUN spends WIDTH shift cycles plus one terminal cycle at cnt==WIDTH.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bor_d   = bor_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          bor_d   = borrowin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CW'(WIDTH)) begin
          state_d = DONE;
        end else begin
          diff_d = {bit_diff, diff_q[WIDTH-1:1]};
          a_d    = {1'b0, a_q[WIDTH-1:1]};
          b_d    = {1'b0, b_q[WIDTH-1:1]};
          bor_d  = bit_bor;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bor_q   <= bor_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  import serial_arith_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       iv8, ir8, ov8, or8, bi8, bo8;
  logic [7:0] a8, b8, d8;
  // 4-bit instance
  logic       iv4, ir4, ov4, or4, bi4, bo4;
  logic [3:0] a4, b4, d4;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .borrowin(bi8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .borrowout(bo8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .borrowin(bi4),
    .out_valid(ov4), .out_ready(or4), .diff(d4), .borrowout(bo4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operand set into dut8 and waits for out_valid.
  // lat counts rising edges from the handshake edge to out_valid.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output int lat, output logic busy_rdy);
    int w;
    a8 = a; b8 = b; bi8 = bin; iv8 = 1'b1; w = 0;
    while (ir8 !== 1'b1 && w < 50) begin tick(); w++; end
    tick();
    iv8 = 1'b0; lat = 0; busy_rdy = 1'b0;
    while (ov8 !== 1'b1 && lat < 50) begin
      if (ir8 !== 1'b0) busy_rdy = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic consume8();
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++; if (ov8 !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", ov8); end
    n_cmp++; if (ir8 !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready_held: got %b want 0", ir8); end
    n_cmp++; if (d8 !== 8'h00) begin n_bad++; $display("FAIL rst_diff: got %h want 00", d8); end
    n_cmp++; if (bo8 !== 1'b0) begin n_bad++; $display("FAIL rst_borrow: got %b want 0", bo8); end
    reset = 1'b0;
    #1;
    n_cmp++; if (ir8 !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready_release: got %b want 1", ir8); end
    tick();
  endtask

  task automatic test_basic();
    int lat; logic busy;
    run_op8(8'h05, 8'h03, 1'b0, lat, busy);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL basic_latency: got %0d want 9", lat); end
    n_cmp++; if (d8 !== 8'h02) begin n_bad++; $display("FAIL basic_diff: got %h want 02", d8); end
    n_cmp++; if (bo8 !== 1'b0) begin n_bad++; $display("FAIL basic_borrow: got %b want 0", bo8); end
    consume8();
  endtask

  task automatic test_borrow();
    int lat; logic busy;
    run_op8(8'h00, 8'h01, 1'b0, lat, busy);
    n_cmp++; if (d8 !== 8'hFF) begin n_bad++; $display("FAIL underflow_diff: got %h want ff", d8); end
    n_cmp++; if (bo8 !== 1'b1) begin n_bad++; $display("FAIL underflow_borrow: got %b want 1", bo8); end
    consume8();
    run_op8(8'h10, 8'h10, 1'b1, lat, busy);
    n_cmp++; if (d8 !== 8'hFF) begin n_bad++; $display("FAIL equal_bin_diff: got %h want ff", d8); end
    n_cmp++; if (bo8 !== 1'b1) begin n_bad++; $display("FAIL equal_bin_borrow: got %b want 1", bo8); end
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL equal_bin_latency: got %0d want 9", lat); end
    consume8();
  endtask

  task automatic test_full_range();
    int lat; logic busy;
    run_op8(8'hFF, 8'h00, 1'b1, lat, busy);
    n_cmp++; if (d8 !== 8'hFE) begin n_bad++; $display("FAIL fullrange_diff: got %h want fe", d8); end
    n_cmp++; if (bo8 !== 1'b0) begin n_bad++; $display("FAIL fullrange_borrow: got %b want 0", bo8); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL run_in_ready: got %b want 0", busy); end
    n_cmp++; if (ir8 !== 1'b0) begin n_bad++; $display("FAIL done_in_ready: got %b want 0", ir8); end
    consume8();
    n_cmp++; if (ir8 !== 1'b1) begin n_bad++; $display("FAIL post_done_in_ready: got %b want 1", ir8); end
    n_cmp++; if (ov8 !== 1'b0) begin n_bad++; $display("FAIL post_done_out_valid: got %b want 0", ov8); end
  endtask

  task automatic test_backpressure();
    int lat; logic busy;
    run_op8(8'h37, 8'h12, 1'b0, lat, busy);
    a8 = 8'h99; b8 = 8'h11; bi8 = 1'b0; iv8 = 1'b1; or8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (ov8 !== 1'b1) begin n_bad++; $display("FAIL stall_out_valid[%0d]: got %b want 1", i, ov8); end
      n_cmp++; if (d8 !== 8'h25) begin n_bad++; $display("FAIL stall_diff[%0d]: got %h want 25", i, d8); end
      n_cmp++; if (bo8 !== 1'b0) begin n_bad++; $display("FAIL stall_borrow[%0d]: got %b want 0", i, bo8); end
      n_cmp++; if (ir8 !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, ir8); end
    end
    // out_ready and in_valid together: result completes, operands wait for IDLE.
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    n_cmp++; if (ir8 !== 1'b1) begin n_bad++; $display("FAIL overlap_in_ready: got %b want 1", ir8); end
    n_cmp++; if (ov8 !== 1'b0) begin n_bad++; $display("FAIL overlap_out_valid: got %b want 0", ov8); end
    run_op8(8'h99, 8'h11, 1'b0, lat, busy);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL back_to_back_latency: got %0d want 9", lat); end
    n_cmp++; if (d8 !== 8'h88) begin n_bad++; $display("FAIL back_to_back_diff: got %h want 88", d8); end
    n_cmp++; if (bo8 !== 1'b0) begin n_bad++; $display("FAIL back_to_back_borrow: got %b want 0", bo8); end
    consume8();
  endtask

  task automatic test_reset_mid();
    int lat; logic busy;
    a8 = 8'hC3; b8 = 8'h3C; bi8 = 1'b1; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (ov8 !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", ov8); end
    n_cmp++; if (d8 !== 8'h00) begin n_bad++; $display("FAIL midrst_diff: got %h want 00", d8); end
    n_cmp++; if (bo8 !== 1'b0) begin n_bad++; $display("FAIL midrst_borrow: got %b want 0", bo8); end
    n_cmp++; if (ir8 !== 1'b0) begin n_bad++; $display("FAIL midrst_in_ready_held: got %b want 0", ir8); end
    reset = 1'b0;
    #1;
    n_cmp++; if (ir8 !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready_release: got %b want 1", ir8); end
    tick();
    run_op8(8'hA5, 8'h5A, 1'b0, lat, busy);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL after_rst_latency: got %0d want 9", lat); end
    n_cmp++; if (d8 !== 8'h4B) begin n_bad++; $display("FAIL after_rst_diff: got %h want 4b", d8); end
    n_cmp++; if (bo8 !== 1'b0) begin n_bad++; $display("FAIL after_rst_borrow: got %b want 0", bo8); end
    consume8();
  endtask

  task automatic test_exhaustive4();
    logic [32:0] r;
    int lat, w;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bj = 0; bj < 16; bj++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a4 = ai[3:0]; b4 = bj[3:0]; bi4 = ci[0]; iv4 = 1'b1; w = 0;
          while (ir4 !== 1'b1 && w < 50) begin tick(); w++; end
          tick();
          iv4 = 1'b0; lat = 0;
          while (ov4 !== 1'b1 && lat < 50) begin tick(); lat++; end
          r = ref_sub({28'd0, ai[3:0]}, {28'd0, bj[3:0]}, ci[0], 4);
          repeat ($urandom_range(0, 3)) tick();
          n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL w4_latency a=%h b=%h bin=%0d: got %0d want 5", ai, bj, ci, lat); end
          n_cmp++; if (d4 !== r[3:0]) begin n_bad++; $display("FAIL w4_diff a=%h b=%h bin=%0d: got %h want %h", ai, bj, ci, d4, r[3:0]); end
          n_cmp++; if (bo4 !== r[32]) begin n_bad++; $display("FAIL w4_borrow a=%h b=%h bin=%0d: got %b want %b", ai, bj, ci, bo4, r[32]); end
          or4 = 1'b1;
          tick();
          or4 = 1'b0;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
    iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; bi4 = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_full_range();
    test_backpressure();
    test_reset_mid();
    test_exhaustive4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
